// File: rtl/mux2_rr_arbiter.sv
// ============================================================================
// Module  : mux2_rr_arbiter
// Brief   : Two-requester round-robin arbiter sharing a WIDTH-bit 2:1 mux,
//           with burst limit and valid/ready output. Optional macro STATS_EN
//           adds per-requester transfer counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mux2_rr_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic             ready0,
  output logic             ready1,
  output logic             grant0,
  output logic             grant1,
  output logic             select,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready
`ifdef STATS_EN
  ,
  output logic [CNT_W-1:0] xfer_cnt0,
  output logic [CNT_W-1:0] xfer_cnt1
`endif
);

  localparam int c_BW = $clog2(MAX_HOLD + 1);
  localparam logic [c_BW-1:0] c_BURST_LAST = c_BW'(MAX_HOLD - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_GNT0 = 2'd1;
  localparam logic [1:0] c_GNT1 = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [c_BW-1:0] burst_q, burst_d;
  logic            last_q, last_d;
  logic            select_q, select_d;
  logic            w_xfer0, w_xfer1;

  assign w_xfer0   = (state_q == c_GNT0) && req0 && out_ready;
  assign w_xfer1   = (state_q == c_GNT1) && req1 && out_ready;
  assign ready0    = w_xfer0;
  assign ready1    = w_xfer1;
  assign grant0    = (state_q == c_GNT0);
  assign grant1    = (state_q == c_GNT1);
  assign select    = select_q;
  assign out       = select_q ? d1 : d0;
  assign out_valid = ((state_q == c_GNT0) && req0) || ((state_q == c_GNT1) && req1);

  always_comb begin
    state_d  = state_q;
    burst_d  = burst_q;
    last_d   = last_q;
    select_d = select_q;
    case (state_q)
      c_IDLE: begin
        // last_q names the previous owner, so a tie goes to the other side
        if (req0 && (!req1 || last_q)) begin
          state_d  = c_GNT0;
          select_d = 1'b0;
          last_d   = 1'b0;
        end else if (req1) begin
          state_d  = c_GNT1;
          select_d = 1'b1;
          last_d   = 1'b1;
        end
      end
      c_GNT0: begin
        if (!req0) begin
          burst_d = '0;
          if (req1) begin
            state_d  = c_GNT1;
            select_d = 1'b1;
            last_d   = 1'b1;
          end else begin
            state_d = c_IDLE;
          end
        end else if (out_ready) begin
          if (burst_q == c_BURST_LAST) begin
            burst_d = '0;
            if (req1) begin
              state_d  = c_GNT1;
              select_d = 1'b1;
              last_d   = 1'b1;
            end
          end else begin
            burst_d = burst_q + c_BW'(1);
          end
        end
      end
      c_GNT1: begin
        if (!req1) begin
          burst_d = '0;
          if (req0) begin
            state_d  = c_GNT0;
            select_d = 1'b0;
            last_d   = 1'b0;
          end else begin
            state_d = c_IDLE;
          end
        end else if (out_ready) begin
          if (burst_q == c_BURST_LAST) begin
            burst_d = '0;
            if (req0) begin
              state_d  = c_GNT0;
              select_d = 1'b0;
              last_d   = 1'b0;
            end
          end else begin
            burst_d = burst_q + c_BW'(1);
          end
        end
      end
      default: begin
        state_d = c_IDLE;
        burst_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= c_IDLE;
      burst_q  <= '0;
      last_q   <= 1'b1;
      select_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      burst_q  <= burst_d;
      last_q   <= last_d;
      select_q <= select_d;
    end
  end

`ifdef STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (w_xfer0) cnt0_q <= cnt0_q + CNT_W'(1);
      if (w_xfer1) cnt1_q <= cnt1_q + CNT_W'(1);
    end
  end

  assign xfer_cnt0 = cnt0_q;
  assign xfer_cnt1 = cnt1_q;
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux2_rr_arbiter.sv
// ============================================================================
// Module  : tb_mux2_rr_arbiter
// Brief   : Directed + random bench for mux2_rr_arbiter against an
//           owner/burst-count reference model (STATS_EN aware).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux2_rr_arbiter;
  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 4;
  localparam int CNT_W    = 16;

  logic             clk = 1'b0;
  logic             reset, req0, req1, out_ready;
  logic [WIDTH-1:0] d0, d1;
  logic             ready0, ready1, grant0, grant1, select, out_valid;
  logic [WIDTH-1:0] out;
`ifdef STATS_EN
  logic [CNT_W-1:0] xfer_cnt0, xfer_cnt1;
`endif

  always #5 clk = ~clk;

  mux2_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .d0(d0), .d1(d1),
    .ready0(ready0), .ready1(ready1), .grant0(grant0), .grant1(grant1),
    .select(select), .out(out), .out_valid(out_valid), .out_ready(out_ready)
`ifdef STATS_EN
    , .xfer_cnt0(xfer_cnt0), .xfer_cnt1(xfer_cnt1)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model: owner (-1 = none), transfers in current burst, last owner
  int m_own, m_burst, m_last, m_sel, m_cnt0, m_cnt1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic take(input int k);
    m_own  = k;
    m_last = k;
    m_sel  = k;
  endtask

  task automatic model_step();
    bit r [2];
    int n, o;
    r[0] = req0;
    r[1] = req1;
    if (reset) begin
      m_own = -1; m_burst = 0; m_last = 1; m_sel = 0; m_cnt0 = 0; m_cnt1 = 0;
    end else if (m_own < 0) begin
      if (r[0] && r[1]) take(1 - m_last);
      else if (r[0])    take(0);
      else if (r[1])    take(1);
    end else begin
      n = m_own;
      o = 1 - n;
      if (!r[n]) begin
        m_burst = 0;
        if (r[o]) take(o);
        else m_own = -1;
      end else if (out_ready) begin
        if (n == 0) m_cnt0++; else m_cnt1++;
        m_burst++;
        if (m_burst == MAX_HOLD) begin
          m_burst = 0;
          if (r[o]) take(o);
        end
      end
    end
  endtask

  task automatic check_all();
    logic ev, r0, r1;
    ev = (m_own == 0 && req0) || (m_own == 1 && req1);
    r0 = (m_own == 0) && req0 && out_ready;
    r1 = (m_own == 1) && req1 && out_ready;
    chk("grant0", {31'b0, grant0}, {31'b0, m_own == 0});
    chk("grant1", {31'b0, grant1}, {31'b0, m_own == 1});
    chk("select", {31'b0, select}, m_sel);
    chk("out_valid", {31'b0, out_valid}, {31'b0, ev});
    chk("ready0", {31'b0, ready0}, {31'b0, r0});
    chk("ready1", {31'b0, ready1}, {31'b0, r1});
    chk("out", {24'b0, out}, {24'b0, (m_sel != 0) ? d1 : d0});
`ifdef STATS_EN
    chk("xfer_cnt0", {16'b0, xfer_cnt0}, m_cnt0 & 32'hFFFF);
    chk("xfer_cnt1", {16'b0, xfer_cnt1}, m_cnt1 & 32'hFFFF);
`endif
  endtask

  // Inputs are set just after a rising edge; outputs are checked mid-cycle.
  task automatic cycle();
    #3;
    check_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    reset = 1'b1; req0 = 1'b1; req1 = 1'b1; out_ready = 1'b0;
    d0 = 8'h3C; d1 = 8'hA5;
    @(posedge clk);
    model_step();
    #1;

    // Reset held with both requests, then release: req0 wins the first tie
    cycle(); cycle();
    reset = 1'b0;
    cycle();
    chk("first_grant0", {31'b0, grant0}, 32'd1);

    // Only requester 1, continuous acceptance
    req0 = 1'b0; d1 = 8'hA5; out_ready = 1'b1;
    cycle();
    chk("req1_out", {24'b0, out}, 32'hA5);
    repeat (11) cycle();

    // Both requesting: 4/4 alternation with no bubble
    req0 = 1'b1; d0 = 8'h5A;
    repeat (24) cycle();

    // Stall in GNT0 while req1 waits
    reset = 1'b1; cycle(); reset = 1'b0;
    cycle();
    out_ready = 1'b0;
    repeat (20) cycle();
    chk("stall_grant0", {31'b0, grant0}, 32'd1);
    out_ready = 1'b1;
    repeat (6) cycle();

    // Drop req0 after 2 transfers in GNT0: direct handover
    reset = 1'b1; cycle(); reset = 1'b0;
    cycle();
    repeat (2) cycle();
    req0 = 1'b0;
    cycle();
    chk("handover_grant1", {31'b0, grant1}, 32'd1);

    // Reset mid-burst in GNT1
    repeat (2) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0; req1 = 1'b0;
    cycle();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 39) == 0);
      req0      = ($urandom_range(0, 3) != 0);
      req1      = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      d0        = 8'($urandom);
      d1        = 8'($urandom);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
